// File: rtl/memory_access_stage.sv
// Memory pipeline stage: forwards ALU results, performs aligned byte/half/word
// loads and stores over a req/ack bus, and flags misaligned accesses and timeouts.
module memory_access_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_mem,
    input  logic [3:0]  ex_op,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    input  logic        ex_wen,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_wen,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        exc_misaligned,
    output logic        exc_bus
);
    typedef enum logic {IDLE, BUS} state_t;

    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [9:0]  tcnt;
    logic        ld_store, ld_unsigned, ld_wen;
    logic [1:0]  ld_size, ld_off;
    logic [4:0]  ld_rd;
    logic        accept, misaligned, done_ack, done_to;

    assign ex_ready = (state == IDLE);
    assign accept   = ex_valid && ex_ready;
    assign done_ack = (state == BUS) && mem_ack;
    assign done_to  = (state == BUS) && !mem_ack && (tcnt == TO_LAST);

    always_comb begin
        misaligned = 1'b0;
        case (ex_op[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = ex_addr[0];
            default: misaligned = (ex_addr[1:0] != 2'b00);
        endcase
    end

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then extend to 32 bits.
    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] off,
                                                 input logic uns, input logic [31:0] rd);
        logic [31:0] lane;
        lane = rd >> {off, 3'b000};
        case (size)
            2'b00:   return uns ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'b01:   return uns ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: return rd;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && ex_mem && !misaligned) state_nx = BUS;
            BUS:     if (done_ack || done_to) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid       <= 1'b0;
            wb_data        <= '0;
            wb_rd          <= '0;
            wb_wen         <= 1'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_be         <= '0;
            mem_wdata      <= '0;
            exc_misaligned <= 1'b0;
            exc_bus        <= 1'b0;
            tcnt           <= '0;
            ld_store       <= 1'b0;
            ld_unsigned    <= 1'b0;
            ld_wen         <= 1'b0;
            ld_size        <= '0;
            ld_off         <= '0;
            ld_rd          <= '0;
        end else begin
            wb_valid       <= 1'b0;
            exc_misaligned <= 1'b0;
            exc_bus        <= 1'b0;
            if (accept) begin
                if (!ex_mem || misaligned) begin
                    wb_valid       <= 1'b1;
                    wb_data        <= ex_addr;
                    wb_rd          <= ex_rd;
                    wb_wen         <= ex_wen && !ex_mem;
                    exc_misaligned <= ex_mem;
                end else begin
                    ld_store    <= ex_op[3];
                    ld_unsigned <= ex_op[2];
                    ld_size     <= ex_op[1:0];
                    ld_off      <= ex_addr[1:0];
                    ld_rd       <= ex_rd;
                    ld_wen      <= ex_wen;
                    tcnt        <= '0;
                    mem_req     <= 1'b1;
                    mem_we      <= ex_op[3];
                    mem_addr    <= {ex_addr[31:2], 2'b00};
                    mem_be      <= lane_be(ex_op[1:0], ex_addr[1:0]);
                    mem_wdata   <= lane_wdata(ex_op[1:0], ex_wdata);
                end
            end else if (done_ack) begin
                mem_req  <= 1'b0;
                wb_valid <= 1'b1;
                wb_rd    <= ld_rd;
                wb_wen   <= ld_store ? 1'b0 : ld_wen;
                wb_data  <= ld_store ? 32'b0 : load_extract(ld_size, ld_off, ld_unsigned, mem_rdata);
            end else if (done_to) begin
                mem_req  <= 1'b0;
                wb_valid <= 1'b1;
                wb_rd    <= ld_rd;
                wb_wen   <= 1'b0;
                wb_data  <= '0;
                exc_bus  <= 1'b1;
            end else if (state == BUS) begin
                tcnt <= tcnt + 10'd1;
            end
        end
    end
endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Pipeline memory stage between the execute stage and the writeback stage; the synthesizable replacement for the memory-stage mock used in `master`. It accepts one execute result at a time, performs aligned byte, half or word loads and stores over a single-master req/ack data bus with variable latency, and delivers the (extended) result to writeback. While a bus access is outstanding it back-pressures execute. It also flags misaligned accesses and bus timeouts.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles `mem_req` may stay high without `mem_ack` before the access is abandoned (1..1023).

Ports:
- clk  in  1  single clock for the block.
- rst  in  1  reset, asynchronous, active-high.
- ex_valid  in  1  execute presents an instruction this cycle.
- ex_ready  out  1  stage can accept; transfer occurs when `ex_valid && ex_ready` at posedge.
- ex_mem  in  1  instruction is a load/store (0 = pass-through ALU result).
- ex_op  in  4  [3] store, [2] unsigned load, [1:0] size: 00 byte, 01 half, 10 word (11 illegal, treated as word).
- ex_addr  in  32  byte address, or ALU result when `ex_mem=0`.
- ex_wdata  in  32  store data (low bits significant for sb/sh).
- ex_rd  in  5  destination register.
- ex_wen  in  1  destination write enable.
- wb_valid  out  1  one-cycle pulse: result for writeback.
- wb_data  out  32  result data.
- wb_rd  out  5  destination register.
- wb_wen  out  1  register write enable (forced 0 on store, exception).
- mem_req  out  1  bus request, held until ack or timeout.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, bits [1:0] always 00.
- mem_be  out  4  byte enables, little-endian lanes (be[0] = bits 7:0).
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read data, valid in the cycle `mem_ack=1`.
- mem_ack  in  1  bus completion; ignored while `mem_req=0`.
- exc_misaligned  out  1  one-cycle pulse with the faulting `wb_valid`.
- exc_bus  out  1  one-cycle pulse on timeout, with `wb_valid`.

## Operation
- FSM: IDLE, BUS. `ex_ready = (state==IDLE)`.
- IDLE, accepted non-memory op: next cycle `wb_valid=1`, `wb_data=ex_addr`, `wb_rd/wb_wen` passed through.
- IDLE, accepted memory op, misaligned (half with addr[0]=1, word with addr[1:0]≠0): no bus access; next cycle `wb_valid=1`, `wb_wen=0`, `exc_misaligned=1`, `wb_data=ex_addr`.
- IDLE, accepted aligned memory op: latch op, addr, rd, wen. Go to BUS. Drive `mem_req=1`, `mem_addr={addr[31:2],2'b00}`. Bus outputs stay stable until the access completes.
- Store lanes: sb `be=0001<<addr[1:0]`, wdata = byte ×4; sh `be = addr[1] ? 1100 : 0011`, wdata = half ×2; sw `be=1111`. Loads drive `be` the same way.
- BUS, `mem_ack=1`: deassert req next cycle, return to IDLE, `wb_valid=1` next cycle.
  - Loads: extract the selected lane, sign- or zero-extend per [2], `wb_wen=latched wen`.
  - Stores: `wb_wen=0`, `wb_data=0`.
- BUS, timeout counter reaches TIMEOUT with no ack: drop req, return to IDLE, next cycle `wb_valid=1`, `wb_wen=0`, `exc_bus=1`, `wb_data=0`.
- A late ack arriving after timeout, while `mem_req=0`, is ignored.

## Timing
- Reset (async assert, sync release): state IDLE, `ex_ready=1`. All other outputs 0: `wb_valid`, `wb_data`, `wb_rd`, `wb_wen`, `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`, both exc flags, timeout counter.
- Reset mid-access aborts it. `mem_req` falls immediately and no `wb_valid` is produced.
- Pass-through and misaligned ops: latency 1 cycle, throughput 1 per cycle.
- Memory op accepted at edge N: `mem_req` high from N. Ack sampled at edge N+k (k≥1, ack in first req cycle allowed). `wb_valid` high in cycle after edge N+k; `ex_ready` high again in that same cycle. Back-to-back access therefore needs ≥2 cycles per op.
- Timeout: req high exactly TIMEOUT cycles.
- All `wb_*` and exc outputs are registered. `wb_data/wb_rd/wb_wen` hold their last value when `wb_valid=0`.

## Test plan
- Reset, then pass-through addr=0x0000_1234, rd=5, wen=1 -> next cycle wb_valid, wb_data=0x1234, wb_rd=5, wb_wen=1.
- sb addr=0x103, wdata=0x0000_00AB, ack after 3 cycles -> mem_addr=0x100, be=1000, mem_wdata=0xABABABAB, ex_ready low 3 cycles, wb_wen=0.
- lb addr=0x102, rdata=0x1280_7F00 -> wb_data=0xFFFF_FF80; lbu -> 0x0000_0080; lh addr=0x102 -> 0x0000_1280.
- lw addr=0x206 -> no mem_req, exc_misaligned pulse, wb_wen=0, wb_data=0x206.
- TIMEOUT=4, lw never acked -> req high 4 cycles, exc_bus pulse, then late ack ignored.
- Assert rst during BUS -> mem_req 0 asynchronously, no wb_valid, ex_ready=1 after release.
